rr_mux: RTL and testbench
=========================

RR_MUX -- requirements
Module: rr_mux

Interface
REQ-001 The block SHALL have one clock and one reset; reset SHALL be synchronous and active-high.
REQ-002 Parameter N, default 4, SHALL be the data width per channel in bits.
REQ-003 Parameter CHANNELS, default 4, SHALL be the input channel count; legal values are 2..16, including non-powers of two.
REQ-004 Localparam SEL_W SHALL equal $clog2(CHANNELS) and SHALL be the channel index width.
REQ-005 clk  input  1  SHALL be the clock; all state updates on its rising edge.
REQ-006 rst  input  1  SHALL be the synchronous active-high reset.
REQ-007 in_data  input  CHANNELS*N  SHALL carry the packed channel data; channel k occupies bits [k*N +: N].
REQ-008 in_valid  input  CHANNELS  SHALL carry one bit per channel; the bit high means the channel offers data.
REQ-009 in_ready  output  CHANNELS  SHALL carry one bit per channel; the bit high means the block accepts that channel this cycle.
REQ-010 out_data  output  N  SHALL be the registered selected data.
REQ-011 out_valid  output  1  SHALL indicate that out_data and out_select hold an unconsumed word.
REQ-012 out_ready  input  1  SHALL indicate that the downstream consumer takes the word this cycle.
REQ-013 out_select  output  SEL_W  SHALL be the source channel index of the current out_data.

Function
REQ-014 The internal signal load SHALL equal (!out_valid || out_ready).
REQ-015 When load=1, the arbiter SHALL grant the first channel with in_valid=1, searching from last_grant+1 upward and wrapping from CHANNELS-1 to 0.
REQ-016 in_ready SHALL be combinational, one-hot or zero, high only for the granted channel, and high only while load=1.
REQ-017 in_ready SHALL NOT depend on in_data or out_data.
REQ-018 On transfer (in_valid[g] && in_ready[g]), the next edge SHALL perform all of: out_data<=channel g data, out_select<=g, out_valid<=1, last_grant<=g.
REQ-019 Latency SHALL be one cycle from input transfer to out_valid.
REQ-020 Throughput SHALL be one word per cycle while out_ready=1.
REQ-021 When load=1 and no in_valid bit is set, out_valid SHALL go to 0 at the next edge; out_data, out_select and last_grant SHALL hold.
REQ-022 When out_valid=1 and out_ready=0, out_data, out_select, out_valid and last_grant SHALL hold, and in_ready SHALL be all zero.
REQ-023 A single requesting channel SHALL be granted on consecutive cycles with no bubble.
REQ-024 Under continuous requests from all channels, each channel SHALL be granted exactly once per CHANNELS grants.
REQ-025 Data SHALL pass unmodified, with no width change.

Reset
REQ-026 While rst=1 at an edge: out_valid<=0, out_data<=0, out_select<=0, last_grant<=CHANNELS-1, so channel 0 has first priority after reset.
REQ-027 While rst=1, in_ready SHALL be all zero.
REQ-028 A reset asserted mid-stream SHALL discard any held output word; no transfer SHALL be counted in that cycle.

Configuration
REQ-029 The macro RR_MUX_FIXED_PRI_EN SHALL select the arbitration mode.
REQ-030 With RR_MUX_FIXED_PRI_EN defined, arbitration SHALL be fixed priority: the lowest valid index always wins, and last_grant SHALL be unused.
REQ-031 With RR_MUX_FIXED_PRI_EN undefined, arbitration SHALL be round-robin as specified in REQ-015 and REQ-024.
REQ-032 All other behaviour and all ports SHALL be identical in both modes.

Verification
REQ-033 Scenario: N=4, CHANNELS=4, in_data={4,3,2,1}, in_valid=4'b1111, out_ready=1 for 8 cycles -> out_select sequence 0,1,2,3,0,1,2,3; out_data sequence 1,2,3,4,1,2,3,4.
REQ-034 Scenario: only in_valid[2]=1 for 5 cycles, out_ready=1 -> in_ready=4'b0100 every cycle; 5 consecutive outputs with out_select=2 and no gap.
REQ-035 Scenario: out_valid=1 and out_ready held 0 for 3 cycles while all channels are valid -> in_ready=0 and out_data/out_select stable; when out_ready rises, the next grant follows the held channel.
REQ-036 Scenario: rst pulsed while out_valid=1 with out_select=2 -> the next cycle shows out_valid=0 and out_select=0; the first grant goes to channel 0.
REQ-037 Scenario: CHANNELS=3 with all channels valid -> the grant wraps 2->0 and index 3 never appears.
REQ-038 Scenario: RR_MUX_FIXED_PRI_EN defined, in_valid=4'b1010 for 4 cycles -> out_select=1 every cycle.

Source files
------------

// File: rtl/rr_mux.sv
// rr_mux: registered N-bit mux with round-robin arbitration over CHANNELS valid/ready inputs.
// Define RR_MUX_FIXED_PRI_EN to select fixed priority (lowest valid index wins) instead.
module rr_mux #(
   parameter int N        = 4,
   parameter int CHANNELS = 4,
   localparam int SEL_W   = $clog2(CHANNELS)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [CHANNELS*N-1:0] in_data,
   input  logic [CHANNELS-1:0]   in_valid,
   output logic [CHANNELS-1:0]   in_ready,
   output logic [N-1:0]          out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [SEL_W-1:0]      out_select
);

   logic                load_s;
   logic                found_s;
   logic [SEL_W-1:0]    grant_s;
   logic [SEL_W-1:0]    idx_s;
   logic [N-1:0]        sel_data_s;
   logic [CHANNELS-1:0] in_ready_s;
   logic [N-1:0]        out_data_r;
   logic                out_valid_r;
   logic [SEL_W-1:0]    out_select_r;
`ifndef RR_MUX_FIXED_PRI_EN
   logic [SEL_W-1:0]    last_grant_r;
`endif

   // The output register can take a new word when empty or being drained.
   assign load_s = !out_valid_r || out_ready;

   // Pick the first requesting channel in the active search order.
   always_comb begin
      found_s = 1'b0;
      grant_s = '0;
      idx_s   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
`ifdef RR_MUX_FIXED_PRI_EN
         idx_s = SEL_W'(i);
`else
         idx_s = SEL_W'((int'(last_grant_r) + 1 + i) % CHANNELS);
`endif
         if (!found_s && in_valid[idx_s]) begin
            found_s = 1'b1;
            grant_s = idx_s;
         end else begin
            found_s = found_s;
         end
      end
   end

   // Select the granted channel's data word.
   always_comb begin
      sel_data_s = '0;
      for (int k = 0; k < CHANNELS; k++) begin
         if (grant_s == SEL_W'(k)) begin
            sel_data_s = in_data[k*N +: N];
         end else begin
            sel_data_s = sel_data_s;
         end
      end
   end

   // Ready is one-hot on the grant, and only when a word can actually be loaded.
   always_comb begin
      in_ready_s = '0;
      if (load_s && found_s && !rst) begin
         in_ready_s[grant_s] = 1'b1;
      end else begin
         in_ready_s = '0;
      end
   end

   // Output word register and arbitration history.
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid_r  <= 1'b0;
         out_data_r   <= '0;
         out_select_r <= '0;
`ifndef RR_MUX_FIXED_PRI_EN
         last_grant_r <= SEL_W'(CHANNELS - 1);
`endif
      end else if (load_s) begin
         if (found_s) begin
            out_valid_r  <= 1'b1;
            out_data_r   <= sel_data_s;
            out_select_r <= grant_s;
`ifndef RR_MUX_FIXED_PRI_EN
            last_grant_r <= grant_s;
`endif
         end else begin
            out_valid_r  <= 1'b0;
         end
      end else begin
         out_valid_r  <= out_valid_r;
      end
   end

   assign in_ready   = in_ready_s;
   assign out_data   = out_data_r;
   assign out_valid  = out_valid_r;
   assign out_select = out_select_r;

endmodule

// File: tb/tb_rr_mux.sv
// tb_rr_mux: scoreboard bench for rr_mux (4-channel main instance plus a 3-channel instance).
// Expectations follow RR_MUX_FIXED_PRI_EN when it is defined for the build.
module tb_rr_mux;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic [3:0]  in_valid;
   logic [3:0]  in_ready;
   logic [3:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [1:0]  out_select;

   logic [11:0] c3_in_data;
   logic [2:0]  c3_in_valid;
   logic [2:0]  c3_in_ready;
   logic [3:0]  c3_out_data;
   logic        c3_out_valid;
   logic        c3_out_ready;
   logic [1:0]  c3_out_select;

   int checks = 0;
   int errors = 0;

   typedef struct {
      int         sel;
      logic [3:0] data;
   } exp_t;
   exp_t sb[$];

   bit         mv     = 1'b0;
   int         m_sel  = 0;
   logic [3:0] m_data = 4'd0;
   int         m_last = 3;

   always #5 clk = ~clk;

   rr_mux #(.N(4), .CHANNELS(4)) dut (
      .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .out_select(out_select)
   );

   rr_mux #(.N(4), .CHANNELS(3)) dut3 (
      .clk(clk), .rst(rst), .in_data(c3_in_data), .in_valid(c3_in_valid), .in_ready(c3_in_ready),
      .out_data(c3_out_data), .out_valid(c3_out_valid), .out_ready(c3_out_ready), .out_select(c3_out_select)
   );

   function automatic int model_grant(input logic [15:0] v, input int last, input int nch);
`ifdef RR_MUX_FIXED_PRI_EN
      for (int i = 0; i < nch; i++) if (v[i]) return i;
`else
      for (int i = 1; i <= nch; i++) if (v[(last + i) % nch]) return (last + i) % nch;
`endif
      return -1;
   endfunction

   // One clock of the 4-channel DUT against the reference model.
   task automatic step();
      int         g;
      bit         load_m;
      bit         fresh;
      logic [3:0] exp_rdy;
      exp_t       e;
      #1;
      load_m  = !mv || out_ready;
      g       = model_grant({12'd0, in_valid}, m_last, 4);
      exp_rdy = 4'd0;
      fresh   = 1'b0;
      if (!rst && load_m && g >= 0) begin
         exp_rdy[g] = 1'b1;
         fresh      = 1'b1;
         e.sel      = g;
         e.data     = in_data[g*4 +: 4];
         sb.push_back(e);
      end
      checks++;
      if (in_ready !== exp_rdy) begin
         errors++;
         $display("FAIL in_ready got %b expected %b", in_ready, exp_rdy);
      end
      @(posedge clk);
      #1;
      if (rst) begin
         mv = 1'b0; m_sel = 0; m_data = 4'd0; m_last = 3;
         sb.delete();
      end else if (load_m) begin
         mv = (g >= 0);
         if (fresh) begin
            e      = sb.pop_front();
            m_sel  = e.sel;
            m_data = e.data;
            m_last = g;
         end
      end
      checks++;
      if (out_valid !== mv) begin
         errors++;
         $display("FAIL out_valid got %b expected %b", out_valid, mv);
      end
      checks++;
      if (out_select !== m_sel[1:0] || out_data !== m_data) begin
         errors++;
         $display("FAIL out_word got sel=%0d data=%0d expected sel=%0d data=%0d",
                  out_select, out_data, m_sel, m_data);
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
      c3_in_data = 12'h765; c3_in_valid = 3'b000; c3_out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_all_valid();
      int exp_sel[8];
      int cnt[4];
      exp_sel = '{0, 1, 2, 3, 0, 1, 2, 3};
      cnt     = '{0, 0, 0, 0};
      in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
`ifdef RR_MUX_FIXED_PRI_EN
         exp_sel[i] = 0;
`endif
         checks++;
         if (out_select !== exp_sel[i][1:0] || out_data !== 4'(exp_sel[i] + 1)) begin
            errors++;
            $display("FAIL all_valid[%0d] got sel=%0d data=%0d expected sel=%0d data=%0d",
                     i, out_select, out_data, exp_sel[i], exp_sel[i] + 1);
         end
         cnt[out_select]++;
      end
`ifndef RR_MUX_FIXED_PRI_EN
      checks++;
      if (cnt[0] != 2 || cnt[1] != 2 || cnt[2] != 2 || cnt[3] != 2) begin
         errors++;
         $display("FAIL fairness got %0d %0d %0d %0d expected 2 each", cnt[0], cnt[1], cnt[2], cnt[3]);
      end
`endif
   endtask

   task automatic test_single();
      in_data = 16'h9A5C; in_valid = 4'b0100; out_ready = 1'b1;
      for (int i = 0; i < 5; i++) begin
         step();
         checks++;
         if (out_valid !== 1'b1 || out_select !== 2'd2 || out_data !== 4'hA) begin
            errors++;
            $display("FAIL single[%0d] got v=%b sel=%0d data=%0d expected v=1 sel=2 data=10",
                     i, out_valid, out_select, out_data);
         end
      end
   endtask

   task automatic test_stall();
      in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      for (int i = 0; i < 3; i++) step();
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_idle();
      in_valid = 4'b0000; out_ready = 1'b1;
      step();
      step();
      in_valid = 4'b1000; in_data = 16'hB000;
      step();
   endtask

   task automatic test_reset_midstream();
      in_data = 16'h4321; in_valid = 4'b1111; out_ready = 1'b1;
      for (int k = 0; k < 8 && !(mv && m_sel == 2); k++) step();
`ifndef RR_MUX_FIXED_PRI_EN
      checks++;
      if (out_valid !== 1'b1 || out_select !== 2'd2) begin
         errors++;
         $display("FAIL reach_sel2 got v=%b sel=%0d expected v=1 sel=2", out_valid, out_select);
      end
`endif
      out_ready = 1'b0;
      rst = 1'b1;
      step();
      rst = 1'b0;
      out_ready = 1'b1;
      step();
      checks++;
      if (out_select !== 2'd0 || out_data !== 4'd1) begin
         errors++;
         $display("FAIL post_reset_grant got sel=%0d data=%0d expected sel=0 data=1", out_select, out_data);
      end
   endtask

   task automatic test_fixed_pattern();
      in_data = 16'h7E5D; in_valid = 4'b1010; out_ready = 1'b1;
      for (int i = 0; i < 4; i++) step();
   endtask

   task automatic test_three_channels();
      int         g;
      int         last;
      logic [2:0] er;
      exp_t       e;
      last = 2;
      c3_in_data = 12'h765; c3_in_valid = 3'b111; c3_out_ready = 1'b1;
      for (int i = 0; i < 7; i++) begin
         #1;
         g  = model_grant({13'd0, c3_in_valid}, last, 3);
         er = 3'd0;
         er[g] = 1'b1;
         e.sel  = g;
         e.data = c3_in_data[g*4 +: 4];
         sb.push_back(e);
         checks++;
         if (c3_in_ready !== er) begin
            errors++;
            $display("FAIL c3_in_ready got %b expected %b", c3_in_ready, er);
         end
         @(posedge clk);
         #1;
         e    = sb.pop_front();
         last = g;
         checks++;
         if (c3_out_valid !== 1'b1 || c3_out_select !== e.sel[1:0] || c3_out_data !== e.data ||
             c3_out_select == 2'd3) begin
            errors++;
            $display("FAIL c3_word got v=%b sel=%0d data=%0d expected v=1 sel=%0d data=%0d",
                     c3_out_valid, c3_out_select, c3_out_data, e.sel, e.data);
         end
      end
   endtask

   initial begin
      test_reset();
      test_all_valid();
      test_single();
      test_stall();
      test_idle();
      test_reset_midstream();
      test_fixed_pattern();
      test_three_channels();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
